// File: rtl/ea_calc.sv
// Effective-address calculator for the KS-10 datapath.
// Resolves the I/X/Y fields of a freshly loaded instruction into an 18-bit
// effective address: optional indexing through the AC file, then an
// indirect chain through memory, bounded by MAXIND levels.
//
// Ports (KS-10 bit n of a word maps to vector index 35-n):
//   clk, rst        clock, asynchronous active-low reset
//   clken           clock enable; all state holds while low
//   start           begin a calculation (sampled only in IDLE)
//   instI/X/Y       indirect bit, index AC number, address field
//   xrPREV          previous-context qualifier for the indirect reads
//   abort           abandon an indirect chain at the next MREQ
//   acSEL/acDATA    AC file read port (data one cycle after address)
//   memREQ/memADDR/memPREV/memACK/memDATA   indirect-word read port
//   ea, done        effective address and its one-cycle valid pulse
//   busy            not in IDLE
//   indfault        one-cycle pulse: indirect depth limit reached
//   aborted         one-cycle pulse: chain abandoned on abort
//   indcnt          indirect words fetched in this calculation
module ea_calc #(
  parameter logic [7:0] MAXIND = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        start,
  input  logic        instI,
  input  logic [3:0]  instX,
  input  logic [17:0] instY,
  input  logic        xrPREV,
  input  logic        abort,
  output logic [3:0]  acSEL,
  input  logic [35:0] acDATA,
  output logic        memREQ,
  output logic [17:0] memADDR,
  output logic        memPREV,
  input  logic        memACK,
  input  logic [35:0] memDATA,
  output logic [17:0] ea,
  output logic        done,
  output logic        busy,
  output logic        indfault,
  output logic        aborted,
  output logic [7:0]  indcnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XREAD = 3'd1,
    S_XADD  = 3'd2,
    S_MREQ  = 3'd3,
    S_MWAIT = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        cur_i_q, cur_i_d;
  logic [3:0]  cur_x_q, cur_x_d;
  logic [17:0] cur_y_q, cur_y_d;
  logic [7:0]  indcnt_q, indcnt_d;
  logic [17:0] ea_q, ea_d;
  logic [3:0]  acsel_q, acsel_d;
  logic        memreq_q, memreq_d;
  logic [17:0] memaddr_q, memaddr_d;
  logic        memprev_q, memprev_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        indfault_q, indfault_d;
  logic        aborted_q, aborted_d;

  // Indirect word fields: IR bit 13 -> [22], bits 14:17 -> [21:18], 18:35 -> [17:0]
  logic        mem_i;
  logic [3:0]  mem_x;
  logic [17:0] mem_y;
  assign mem_i = memDATA[22];
  assign mem_x = memDATA[21:18];
  assign mem_y = memDATA[17:0];

  // Left halves of the AC and indirect words play no part in the address
  logic unused_bits;
  assign unused_bits = ^{acDATA[35:18], memDATA[35:23]};

  // Common dispatch after loading a new I/X/Y triple
  function automatic state_e route(input logic i, input logic [3:0] x);
    if (x != 4'd0) return S_XREAD;
    else if (i)    return S_MREQ;
    else           return S_FIN;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state_q <= S_IDLE;
    else if (clken) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = route(instI, instX);
      S_XREAD: state_d = S_XADD;
      S_XADD:  state_d = cur_i_q ? S_MREQ : S_FIN;
      S_MREQ:  begin
        if (indcnt_q == MAXIND || abort) state_d = S_IDLE;
        else                             state_d = S_MWAIT;
      end
      // Abort is deliberately not looked at here: an issued read always completes
      S_MWAIT: if (memACK) state_d = route(mem_i, mem_x);
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and working-register next values
  always_comb begin
    cur_i_d    = cur_i_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    indcnt_d   = indcnt_q;
    ea_d       = ea_q;
    memreq_d   = memreq_q;
    memaddr_d  = memaddr_q;
    memprev_d  = memprev_q;
    done_d     = 1'b0;
    indfault_d = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_i_d  = instI;
          cur_x_d  = instX;
          cur_y_d  = instY;
          indcnt_d = 8'd0;
        end
      end
      // Right-half add; carry out of the 18-bit field is dropped
      S_XADD: cur_y_d = cur_y_q + acDATA[17:0];
      S_MREQ: begin
        if (indcnt_q == MAXIND) begin
          indfault_d = 1'b1;
        end else if (abort) begin
          aborted_d = 1'b1;
        end else begin
          memreq_d  = 1'b1;
          memaddr_d = cur_y_q;
          memprev_d = xrPREV;
        end
      end
      S_MWAIT: begin
        if (memACK) begin
          cur_i_d   = mem_i;
          cur_x_d   = mem_x;
          cur_y_d   = mem_y;
          indcnt_d  = indcnt_q + 8'd1;
          memreq_d  = 1'b0;
          memprev_d = 1'b0;
        end
      end
      S_FIN: begin
        ea_d   = cur_y_q;
        done_d = 1'b1;
      end
      default: ;
    endcase

    // AC address is presented only while the FSM sits in XREAD
    acsel_d = (state_d == S_XREAD) ? cur_x_d : 4'd0;
    busy_d  = (state_d != S_IDLE);
  end

  // Working and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_i_q    <= 1'b0;
      cur_x_q    <= 4'd0;
      cur_y_q    <= 18'd0;
      indcnt_q   <= 8'd0;
      ea_q       <= 18'd0;
      acsel_q    <= 4'd0;
      memreq_q   <= 1'b0;
      memaddr_q  <= 18'd0;
      memprev_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      indfault_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else if (clken) begin
      cur_i_q    <= cur_i_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      indcnt_q   <= indcnt_d;
      ea_q       <= ea_d;
      acsel_q    <= acsel_d;
      memreq_q   <= memreq_d;
      memaddr_q  <= memaddr_d;
      memprev_q  <= memprev_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      indfault_q <= indfault_d;
      aborted_q  <= aborted_d;
    end
  end

  assign acSEL    = acsel_q;
  assign memREQ   = memreq_q;
  assign memADDR  = memaddr_q;
  assign memPREV  = memprev_q;
  assign ea       = ea_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign indfault = indfault_q;
  assign aborted  = aborted_q;
  assign indcnt   = indcnt_q;

endmodule

// File: tb/tb_ea_calc.sv
// Bench for ea_calc: directed scenarios plus randomized chains checked
// against a loop-level model of effective-address resolution.
module tb_ea_calc;

  localparam logic [7:0] MAXIND_TB = 8'd4;

  logic        clk;
  logic        rst;
  logic        clken;
  logic        start;
  logic        instI;
  logic [3:0]  instX;
  logic [17:0] instY;
  logic        xrPREV;
  logic        abort;
  logic [3:0]  acSEL;
  logic [35:0] acDATA;
  logic        memREQ;
  logic [17:0] memADDR;
  logic        memPREV;
  logic        memACK;
  logic [35:0] memDATA;
  logic [17:0] ea;
  logic        done;
  logic        busy;
  logic        indfault;
  logic        aborted;
  logic [7:0]  indcnt;

  int total;
  int bad;

  // AC file and memory images
  logic [35:0] ac [16];
  logic [35:0] mem [logic [17:0]];
  logic [3:0]  acsel_prev;

  // Memory responder controls
  int          wait_cycles;
  int          wcnt;
  bit          resp_en;
  logic        resp_ack;
  logic [35:0] resp_data;
  logic        man_ack;
  logic [35:0] man_data;

  assign memACK  = resp_ack | man_ack;
  assign memDATA = man_ack ? man_data : resp_data;

  // Observation records
  int          req_rises;
  logic        req_prev;
  logic [17:0] addr_seen [$];
  logic        prev_seen [$];
  logic [3:0]  acsel_seen [$];
  logic [17:0] exp_addr [$];

  ea_calc #(.MAXIND(MAXIND_TB)) dut (
    .clk(clk), .rst(rst), .clken(clken), .start(start),
    .instI(instI), .instX(instX), .instY(instY), .xrPREV(xrPREV),
    .abort(abort), .acSEL(acSEL), .acDATA(acDATA),
    .memREQ(memREQ), .memADDR(memADDR), .memPREV(memPREV),
    .memACK(memACK), .memDATA(memDATA), .ea(ea), .done(done),
    .busy(busy), .indfault(indfault), .aborted(aborted), .indcnt(indcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lazily filled memory: unknown words get random contents
  function automatic logic [35:0] mem_rd(input logic [17:0] a);
    logic [35:0] w;
    if (!mem.exists(a)) begin
      w = {4'($urandom), 32'($urandom)};
      w[22] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) w[21:18] = 4'd0;
      mem[a] = w;
    end
    return mem[a];
  endfunction

  // Reference: walk index/indirect chain, tallying reads and enabled cycles
  function automatic void ref_ea(input logic ci, input logic [3:0] cx, input logic [17:0] cy,
                                 output logic [17:0] e, output int n, output bit flt, output int cyc);
    logic [35:0] w;
    bit fin;
    e = 18'd0; n = 0; flt = 0; cyc = 1; fin = 0;
    exp_addr.delete();
    while (!fin) begin
      if (cx != 4'd0) begin
        cy = cy + ac[cx][17:0];
        cyc += 2;
      end
      if (!ci) begin
        e = cy; cyc += 1; fin = 1;
      end else if (n == int'(MAXIND_TB)) begin
        flt = 1; cyc += 1; fin = 1;
      end else begin
        exp_addr.push_back(cy);
        w = mem_rd(cy);
        n++;
        cyc += 2 + wait_cycles;
        ci = w[22]; cx = w[21:18]; cy = w[17:0];
      end
    end
  endfunction

  // AC file (one-cycle read latency) and memory responder
  initial begin
    resp_ack = 1'b0; resp_data = 36'd0; wcnt = 0; acDATA = 36'd0; acsel_prev = 4'd0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      acDATA = ac[acsel_prev];
      acsel_prev = acSEL;
      if (!rst) wcnt = 0;
      else if (resp_en && memREQ && clken) begin
        if (wcnt >= wait_cycles) begin
          resp_ack = 1'b1;
          resp_data = mem_rd(memADDR);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Request and AC-select monitor
  initial begin
    req_rises = 0; req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (memREQ && !req_prev) begin
        req_rises++;
        addr_seen.push_back(memADDR);
        prev_seen.push_back(memPREV);
      end
      req_prev = memREQ;
      if (acSEL != 4'd0) acsel_seen.push_back(acSEL);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one calculation; outcome 0=timeout 1=done 2=indfault 3=aborted
  task automatic run_calc(input logic i, input logic [3:0] x, input logic [17:0] y,
                          input logic prev, output int cyc, output int outcome);
    @(negedge clk);
    start = 1'b1; instI = i; instX = x; instY = y; xrPREV = prev;
    cyc = 0; outcome = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || indfault || aborted) begin
        cyc = k;
        outcome = done ? 1 : (indfault ? 2 : 3);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ea !== 18'd0) begin bad++; $display("FAIL reset_ea: got %0o want 0", ea); end
    total++; if (indcnt !== 8'd0) begin bad++; $display("FAIL reset_indcnt: got %0d want 0", indcnt); end
    total++; if (acSEL !== 4'd0) begin bad++; $display("FAIL reset_acsel: got %0d want 0", acSEL); end
    total++; if (memADDR !== 18'd0) begin bad++; $display("FAIL reset_memaddr: got %0o want 0", memADDR); end
    total++;
    if ({memREQ, memPREV, done, busy, indfault, aborted} !== 6'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {memREQ, memPREV, done, busy, indfault, aborted});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_direct();
    int cyc, oc, b;
    b = req_rises;
    run_calc(1'b0, 4'd0, 18'o123456, 1'b0, cyc, oc);
    total++; if (oc !== 1) begin bad++; $display("FAIL direct_outcome: got %0d want 1", oc); end
    total++; if (cyc !== 2) begin bad++; $display("FAIL direct_latency: got %0d want 2", cyc); end
    total++; if (ea !== 18'o123456) begin bad++; $display("FAIL direct_ea: got %0o want 123456", ea); end
    total++; if (indcnt !== 8'd0) begin bad++; $display("FAIL direct_indcnt: got %0d want 0", indcnt); end
    total++; if (req_rises - b !== 0) begin bad++; $display("FAIL direct_noreq: got %0d want 0", req_rises - b); end
  endtask

  task automatic test_index_wrap();
    int cyc, oc, a0;
    logic [3:0] sel;
    ac[3] = 36'o777777000005;
    a0 = acsel_seen.size();
    run_calc(1'b0, 4'd3, 18'o777776, 1'b0, cyc, oc);
    sel = (acsel_seen.size() > a0) ? acsel_seen[a0] : 4'd0;
    total++; if (oc !== 1) begin bad++; $display("FAIL index_outcome: got %0d want 1", oc); end
    total++; if (cyc !== 4) begin bad++; $display("FAIL index_latency: got %0d want 4", cyc); end
    total++; if (ea !== 18'o000003) begin bad++; $display("FAIL index_ea_wrap: got %0o want 3", ea); end
    total++; if (acsel_seen.size() - a0 !== 1) begin bad++; $display("FAIL index_acsel_cycles: got %0d want 1", acsel_seen.size() - a0); end
    total++; if (sel !== 4'd3) begin bad++; $display("FAIL index_acsel: got %0d want 3", sel); end
  endtask

  task automatic test_indirect_indexed();
    int cyc, oc, b, a0;
    mem.delete();
    mem[18'o1000] = (36'd2 << 18) | 36'o10;
    ac[2] = {18'($urandom), 18'o5};
    wait_cycles = 3;
    b = req_rises; a0 = addr_seen.size();
    run_calc(1'b1, 4'd0, 18'o1000, 1'b1, cyc, oc);
    total++; if (oc !== 1) begin bad++; $display("FAIL ind_outcome: got %0d want 1", oc); end
    total++; if (cyc !== 9) begin bad++; $display("FAIL ind_latency: got %0d want 9", cyc); end
    total++; if (ea !== 18'o15) begin bad++; $display("FAIL ind_ea: got %0o want 15", ea); end
    total++; if (indcnt !== 8'd1) begin bad++; $display("FAIL ind_indcnt: got %0d want 1", indcnt); end
    total++; if (req_rises - b !== 1) begin bad++; $display("FAIL ind_reads: got %0d want 1", req_rises - b); end
    if (addr_seen.size() > a0) begin
      total++; if (addr_seen[a0] !== 18'o1000) begin bad++; $display("FAIL ind_memaddr: got %0o want 1000", addr_seen[a0]); end
      total++; if (prev_seen[a0] !== 1'b1) begin bad++; $display("FAIL ind_memprev: got %0b want 1", prev_seen[a0]); end
    end
  endtask

  task automatic test_maxind();
    int cyc, oc, b, a0, abad;
    mem.delete();
    mem[18'o4444] = (36'd1 << 22) | 36'o4444;
    wait_cycles = 0;
    b = req_rises; a0 = addr_seen.size();
    run_calc(1'b1, 4'd0, 18'o4444, 1'b0, cyc, oc);
    abad = 0;
    for (int j = a0; j < addr_seen.size(); j++) if (addr_seen[j] !== 18'o4444) abad++;
    total++; if (oc !== 2) begin bad++; $display("FAIL maxind_outcome: got %0d want 2", oc); end
    total++; if (req_rises - b !== 4) begin bad++; $display("FAIL maxind_reads: got %0d want 4", req_rises - b); end
    total++; if (indcnt !== 8'd4) begin bad++; $display("FAIL maxind_indcnt: got %0d want 4", indcnt); end
    total++; if (cyc !== 10) begin bad++; $display("FAIL maxind_latency: got %0d want 10", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL maxind_busy: got %0b want 0", busy); end
    total++; if (ea !== 18'o15) begin bad++; $display("FAIL maxind_ea_hold: got %0o want 15", ea); end
    total++; if (abad !== 0) begin bad++; $display("FAIL maxind_addr: got %0d wrong addresses want 0", abad); end
  endtask

  task automatic test_abort();
    int cyc, oc, b;
    run_calc(1'b0, 4'd0, 18'o4321, 1'b0, cyc, oc);
    total++; if (ea !== 18'o4321) begin bad++; $display("FAIL abort_pre_ea: got %0o want 4321", ea); end
    mem.delete();
    mem[18'o2000] = (36'd1 << 22) | 36'o3000;
    mem[18'o3000] = 36'o3100;
    wait_cycles = 3;
    b = req_rises;
    @(negedge clk);
    start = 1'b1; instI = 1'b1; instX = 4'd0; instY = 18'o2000; xrPREV = 1'b0;
    cyc = 0; oc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin instI = 1'b0; instY = 18'o7777; end
      if (memREQ) abort = 1'b1;
      if (done || indfault || aborted) begin
        cyc = k;
        oc = done ? 1 : (indfault ? 2 : 3);
        break;
      end
    end
    start = 1'b0;
    total++; if (oc !== 3) begin bad++; $display("FAIL abort_outcome: got %0d want 3", oc); end
    total++; if (cyc !== 7) begin bad++; $display("FAIL abort_latency: got %0d want 7", cyc); end
    total++; if (req_rises - b !== 1) begin bad++; $display("FAIL abort_reads: got %0d want 1", req_rises - b); end
    total++; if (indcnt !== 8'd1) begin bad++; $display("FAIL abort_indcnt: got %0d want 1", indcnt); end
    total++; if (ea !== 18'o4321) begin bad++; $display("FAIL abort_ea_hold: got %0o want 4321", ea); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
    abort = 1'b0;
  endtask

  task automatic test_clken();
    bit held;
    @(negedge clk);
    start = 1'b1; instI = 1'b0; instX = 4'd0; instY = 18'o7070; clken = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clken_start_gated: got busy %0b want 0", busy); end
    clken = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clken_busy: got %0b want 1", busy); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL clken_done: got %0b want 1", done); end
    clken = 1'b0;
    held = 1;
    repeat (3) begin
      @(negedge clk);
      if (!(done === 1'b1 && busy === 1'b0)) held = 0;
    end
    total++; if (held !== 1) begin bad++; $display("FAIL clken_hold: got %0d want 1", held); end
    clken = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL clken_pulse_end: got %0b want 0", done); end
    total++; if (ea !== 18'o7070) begin bad++; $display("FAIL clken_ea: got %0o want 7070", ea); end
  endtask

  task automatic test_reset_mid();
    bit got;
    resp_en = 0;
    @(negedge clk);
    start = 1'b1; instI = 1'b1; instX = 4'd0; instY = 18'o2222;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (memREQ) begin got = 1; break; end
    end
    total++; if (got !== 1) begin bad++; $display("FAIL rstmid_req: got %0d want 1", got); end
    rst = 1'b0;
    #1;
    total++; if ({ea, indcnt, acSEL, memADDR} !== 48'd0) begin bad++; $display("FAIL rstmid_buses: got %0h want 0", {ea, indcnt, acSEL, memADDR}); end
    total++;
    if ({memREQ, memPREV, done, busy, indfault, aborted} !== 6'd0) begin
      bad++; $display("FAIL rstmid_flags: got %b want 000000", {memREQ, memPREV, done, busy, indfault, aborted});
    end
    @(negedge clk);
    rst = 1'b1;
    man_data = 36'o3333;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    total++; if ({busy, done, memREQ} !== 3'd0) begin bad++; $display("FAIL rstmid_lateack: got %b want 000", {busy, done, memREQ}); end
    total++; if (indcnt !== 8'd0) begin bad++; $display("FAIL rstmid_indcnt: got %0d want 0", indcnt); end
    total++; if (ea !== 18'd0) begin bad++; $display("FAIL rstmid_ea: got %0o want 0", ea); end
    resp_en = 1;
  endtask

  task automatic test_random();
    int cyc, oc, b, a0, n, ecyc, abad;
    bit flt;
    logic [17:0] e, last_ea;
    logic i, prev;
    logic [3:0] x;
    logic [17:0] y;
    last_ea = 18'd0;
    for (int it = 0; it < 30; it++) begin
      mem.delete();
      for (int j = 0; j < 16; j++) ac[j] = {4'($urandom), 32'($urandom)};
      wait_cycles = $urandom_range(0, 3);
      i = 1'($urandom_range(0, 1));
      x = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      y = 18'($urandom);
      prev = 1'($urandom_range(0, 1));
      ref_ea(i, x, y, e, n, flt, ecyc);
      if (!flt) last_ea = e;
      b = req_rises; a0 = addr_seen.size();
      run_calc(i, x, y, prev, cyc, oc);
      abad = 0;
      for (int j = 0; j < n; j++) begin
        if (a0 + j >= addr_seen.size()) abad++;
        else if (addr_seen[a0 + j] !== exp_addr[j] || prev_seen[a0 + j] !== prev) abad++;
      end
      total++; if (oc !== (flt ? 2 : 1)) begin bad++; $display("FAIL rand%0d_outcome: got %0d want %0d", it, oc, flt ? 2 : 1); end
      total++; if (cyc !== ecyc) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, ecyc); end
      total++; if (ea !== last_ea) begin bad++; $display("FAIL rand%0d_ea: got %0o want %0o", it, ea, last_ea); end
      total++; if (indcnt !== 8'(n)) begin bad++; $display("FAIL rand%0d_indcnt: got %0d want %0d", it, indcnt, n); end
      total++; if (req_rises - b !== n) begin bad++; $display("FAIL rand%0d_reads: got %0d want %0d", it, req_rises - b, n); end
      total++; if (abad !== 0) begin bad++; $display("FAIL rand%0d_memaddr: got %0d wrong reads want 0", it, abad); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; clken = 1'b1; start = 1'b0;
    instI = 1'b0; instX = 4'd0; instY = 18'd0; xrPREV = 1'b0; abort = 1'b0;
    man_ack = 1'b0; man_data = 36'd0; resp_en = 1; wait_cycles = 0;
    for (int j = 0; j < 16; j++) ac[j] = 36'd0;
    test_reset();
    test_direct();
    test_index_wrap();
    test_indirect_indexed();
    test_maxind();
    test_abort();
    test_clken();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ea_calc.md
# ea_calc

Effective-address calculator for the KS-10 CPU datapath, directly downstream of the instruction register. On `start` it takes the I, X and Y fields of the instruction just loaded. It resolves indexing through the AC file and follows indirect chains through memory until it produces an 18-bit effective address. Microcode waits on `done` before dispatching the instruction.

## Interface
- `MAXIND`, 8'd255: indirect-depth limit; reaching it raises `indfault`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `clken` in 1: clock enable; when low, all state holds.
- `start` in 1: begin calculation; sampled only in IDLE.
- `instI` in 1: indirect bit (IR bit 13 image).
- `instX` in [14:17]: index AC number.
- `instY` in [18:35]: address field.
- `xrPREV` in 1: index/indirect references use previous context.
- `abort` in 1: interrupt/page-fail request; terminates an indirect chain.
- `acSEL` out [0:3]: AC file read address.
- `acDATA` in [0:35]: AC file read data, valid the cycle after `acSEL` is presented.
- `memREQ` out 1: memory read request.
- `memADDR` out [18:35]: memory read address.
- `memPREV` out 1: previous-context qualifier for the read.
- `memACK` in 1: read complete; `memDATA` valid this cycle.
- `memDATA` in [0:35]: indirect word.
- `ea` out [18:35]: effective address.
- `done` out 1: one-cycle pulse, `ea` valid.
- `busy` out 1: not in IDLE.
- `indfault` out 1: one-cycle pulse, depth limit hit.
- `aborted` out 1: one-cycle pulse, chain abandoned.
- `indcnt` out 8: indirect words fetched in this calculation.

## Operation
- States: IDLE, XREAD, XADD, MREQ, MWAIT, FIN.
- Working registers: `curI`, `curX`, `curY`.
- IDLE: on `start & clken`, load `curI`/`curX`/`curY` from `inst*` and clear `indcnt`.
  - If `curX != 0`, go to XREAD.
  - Else if `curI`, go to MREQ.
  - Else go to FIN.
- XREAD: drive `acSEL = curX`, go to XADD.
- XADD: `curY <= (curY + acDATA[18:35]) mod 2^18`. Carry out of bit 18 is discarded; `acDATA[0:17]` is ignored.
  - Next state is MREQ if `curI`, else FIN.
- MREQ:
  - If `indcnt == MAXIND`: pulse `indfault`, go to IDLE without `done`.
  - Else if `abort`: pulse `aborted`, go to IDLE.
  - Else assert `memREQ` with `memADDR = curY` and `memPREV = xrPREV`, go to MWAIT.
- MWAIT: hold `memREQ` and `memADDR` until `memACK`. On `memACK`:
  - load `curI <= memDATA[13]`, `curX <= memDATA[14:17]`, `curY <= memDATA[18:35]`;
  - increment `indcnt`;
  - route as from IDLE: XREAD if `X != 0`, else MREQ if `I`, else FIN.
- `abort` in MWAIT is ignored until `memACK`. An outstanding read is never dropped; the abort is taken at the next MREQ.
- FIN: `ea <= curY`, pulse `done`, go to IDLE.
- `ea` holds its value until the next FIN. `indcnt` holds until the next `start`.
- `start` while `busy` is ignored.
- `acSEL` is 0 outside XREAD.
- `memREQ` is asserted only in MREQ and MWAIT.
- Reset in any state:
  - state goes to IDLE;
  - `ea`, `indcnt`, `acSEL` and `memADDR` go to 0;
  - `memREQ`, `memPREV`, `done`, `busy`, `indfault` and `aborted` go to 0;
  - any in-flight `memACK` after reset is ignored.

## Timing
- All transitions require `clken`. With `clken` low, outputs hold, including the `done`/`indfault`/`aborted` pulse level.
- Cycle count C0 is the `start` edge.
  - Direct, unindexed: FIN at C1, `done` high in C2. Latency is 2 enabled cycles.
  - Indexed: XREAD C1, XADD C2, FIN C3, `done` in C4.
  - Each indirect level: MREQ 1 cycle, MWAIT ≥1 cycle (W cycles until `memACK`), plus 2 cycles if that word is indexed.
- `memACK` in the same cycle `memREQ` first rises is not accepted. The ack is sampled only in MWAIT.
- `busy` rises the cycle after `start` and falls in the cycle `done`, `indfault` or `aborted` pulses.

## Test plan
- Y=0o123456, X=0, I=0, `start` → `done` 2 cycles later, `ea`=0o123456, `indcnt`=0, no `memREQ`.
- X=3, AC3=0o777777_000005, Y=0o777776 → `acSEL`=3 in XREAD, `ea`=0o000003 (wrap), `done` at cycle 4.
- I=1, Y=0o1000; `memDATA`=word with I=0, X=2, Y=0o10; AC2 RH=0o5; ack after 3 wait cycles → `memADDR`=0o1000, `ea`=0o15, `indcnt`=1.
- Self-pointing indirect word (I=1, Y=own address), `MAXIND`=4 → exactly 4 reads, then `indfault` pulse, no `done`, `busy` low after.
- `abort` asserted during MWAIT of a 2-level chain → first read completes, no second `memREQ`, `aborted` pulse; `start` while busy ignored; `rst` low mid-MWAIT → all outputs 0, a later `memACK` has no effect.
